// File: rtl/spn_req_sched.sv
// Request scheduler in front of the spn_cu cipher core: FIFO-buffered issue, result capture,
// and a one-entry cache for repeated tuples. Optional SPN_SCHED_STATS_EN adds saturating counters.
module spn_req_sched #(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  req_op,
    input  logic [15:0] req_data,
    input  logic [31:0] req_key,
    output logic [1:0]  cu_opcode,
    output logic [15:0] cu_in_data,
    output logic [31:0] cu_key,
    input  logic [15:0] cu_out_data,
    input  logic [1:0]  cu_valid,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [15:0] rsp_data,
    output logic [1:0]  rsp_op,
    output logic        rsp_err
`ifdef SPN_SCHED_STATS_EN
    ,
    output logic [15:0] stat_req,
    output logic [15:0] stat_hit,
    output logic [15:0] stat_err
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = $clog2(TIMEOUT);

    typedef struct packed {
        logic [1:0]  op;
        logic [15:0] data;
        logic [31:0] key;
    } req_t;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    req_t          fifo_mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    state_t        state_q, state_d;
    req_t          cu_q, cu_d;
    req_t          last_q, last_d;
    logic [1:0]    cur_op_q, cur_op_d;
    logic [15:0]   cache_q, cache_d;
    logic          cache_ok_q, cache_ok_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          rsp_valid_q, rsp_valid_d;
    logic [15:0]   rsp_data_q, rsp_data_d;
    logic [1:0]    rsp_op_q, rsp_op_d;
    logic          rsp_err_q, rsp_err_d;

    logic full, empty, push, pop;
    logic head_legal, head_same, cu_done, cu_fail;
    req_t req_in, head;

    assign req_in     = '{op: req_op, data: req_data, key: req_key};
    assign full       = (count_q == CW'(DEPTH));
    assign empty      = (count_q == '0);
    assign req_ready  = !full;
    assign push       = req_valid && !full;
    assign pop        = (state_q == IDLE) && !empty && !rsp_valid_q;
    assign head       = fifo_mem_q[rd_ptr_q];
    assign head_legal = (head.op == 2'b01) || (head.op == 2'b10);
    assign head_same  = (head == last_q);
    assign cu_done    = (state_q == WAIT) && (cu_valid == cur_op_q);
    // A non-zero valid that is not our op (including 11) is a core fault, not a late answer.
    assign cu_fail    = (state_q == WAIT) && !cu_done &&
                        ((cu_valid != 2'b00) || (timer_q == TW'(TIMEOUT - 1)));

    assign cu_opcode  = cu_q.op;
    assign cu_in_data = cu_q.data;
    assign cu_key     = cu_q.key;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_data   = rsp_data_q;
    assign rsp_op     = rsp_op_q;
    assign rsp_err    = rsp_err_q;

    // FIFO storage carries no reset; the pointers alone define its contents.
    always_ff @(posedge clk) begin
        if (push) fifo_mem_q[wr_ptr_q] <= req_in;
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q + AW'(push);
        rd_ptr_d = rd_ptr_q + AW'(pop);
        count_d  = count_q + CW'(push) - CW'(pop);
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (pop) state_d = (!head_legal || head_same) ? RESP : WAIT;
            WAIT: if (cu_done || cu_fail) state_d = RESP;
            RESP: if (rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output / datapath logic
    always_comb begin
        cu_d        = cu_q;
        last_d      = last_q;
        cur_op_d    = cur_op_q;
        cache_d     = cache_q;
        cache_ok_d  = cache_ok_q;
        timer_d     = timer_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        rsp_op_d    = rsp_op_q;
        rsp_err_d   = rsp_err_q;
        case (state_q)
            IDLE: begin
                cu_d.op = 2'b00;
                if (pop) begin
                    cur_op_d = head.op;
                    if (!head_legal || head_same) begin
                        rsp_valid_d = 1'b1;
                        rsp_op_d    = head.op;
                        rsp_err_d   = !head_legal || !cache_ok_q;
                        rsp_data_d  = (head_legal && cache_ok_q) ? cache_q : 16'h0000;
                    end else begin
                        cu_d    = head;
                        last_d  = head;
                        timer_d = '0;
                    end
                end
            end
            WAIT: begin
                if (cu_done) begin
                    rsp_valid_d = 1'b1;
                    rsp_data_d  = cu_out_data;
                    rsp_op_d    = cur_op_q;
                    rsp_err_d   = 1'b0;
                    cache_d     = cu_out_data;
                    cache_ok_d  = 1'b1;
                    cu_d.op     = 2'b00;
                end else if (cu_fail) begin
                    rsp_valid_d = 1'b1;
                    rsp_data_d  = 16'h0000;
                    rsp_op_d    = cur_op_q;
                    rsp_err_d   = 1'b1;
                    cache_ok_d  = 1'b0;
                    cu_d.op     = 2'b00;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            RESP: if (rsp_ready) rsp_valid_d = 1'b0;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            cu_q        <= '0;
            last_q      <= '0;
            cur_op_q    <= 2'b00;
            cache_q     <= 16'h0000;
            cache_ok_q  <= 1'b0;
            timer_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= 16'h0000;
            rsp_op_q    <= 2'b00;
            rsp_err_q   <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            cu_q        <= cu_d;
            last_q      <= last_d;
            cur_op_q    <= cur_op_d;
            cache_q     <= cache_d;
            cache_ok_q  <= cache_ok_d;
            timer_q     <= timer_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_op_q    <= rsp_op_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

`ifdef SPN_SCHED_STATS_EN
    logic        hit_evt, err_evt;
    logic [15:0] stat_req_q, stat_req_d, stat_hit_q, stat_hit_d, stat_err_q, stat_err_d;

    assign hit_evt  = pop && head_legal && head_same && cache_ok_q;
    assign err_evt  = (pop && (!head_legal || (head_same && !cache_ok_q))) || cu_fail;
    assign stat_req = stat_req_q;
    assign stat_hit = stat_hit_q;
    assign stat_err = stat_err_q;

    always_comb begin
        stat_req_d = stat_req_q;
        stat_hit_d = stat_hit_q;
        stat_err_d = stat_err_q;
        if (pop     && stat_req_q != 16'hFFFF) stat_req_d = stat_req_q + 16'd1;
        if (hit_evt && stat_hit_q != 16'hFFFF) stat_hit_d = stat_hit_q + 16'd1;
        if (err_evt && stat_err_q != 16'hFFFF) stat_err_d = stat_err_q + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stat_req_q <= 16'h0000;
            stat_hit_q <= 16'h0000;
            stat_err_q <= 16'h0000;
        end else begin
            stat_req_q <= stat_req_d;
            stat_hit_q <= stat_hit_d;
            stat_err_q <= stat_err_d;
        end
    end
`endif

endmodule

// File: tb/tb_spn_req_sched.sv
// Bench for spn_req_sched: stub cipher core plus a request-level reference model
// (illegal / hit / stale-repeat / miss rules) checked against in-order responses.
module tb_spn_req_sched;

    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 8;

    logic        clk, reset;
    logic        req_valid, req_ready;
    logic [1:0]  req_op;
    logic [15:0] req_data;
    logic [31:0] req_key;
    logic [1:0]  cu_opcode;
    logic [15:0] cu_in_data;
    logic [31:0] cu_key;
    logic [15:0] cu_out_data;
    logic [1:0]  cu_valid;
    logic        rsp_valid, rsp_ready;
    logic [15:0] rsp_data;
    logic [1:0]  rsp_op;
    logic        rsp_err;
`ifdef SPN_SCHED_STATS_EN
    logic [15:0] stat_req, stat_hit, stat_err;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    spn_req_sched #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_data(req_data), .req_key(req_key),
        .cu_opcode(cu_opcode), .cu_in_data(cu_in_data), .cu_key(cu_key),
        .cu_out_data(cu_out_data), .cu_valid(cu_valid),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_op(rsp_op), .rsp_err(rsp_err)
`ifdef SPN_SCHED_STATS_EN
        , .stat_req(stat_req), .stat_hit(stat_hit), .stat_err(stat_err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stub core: latches a non-idle request differing from its previous one, answers next cycle.
    int          stub_mode = 0;   // 0 answers, 1 silent, 2 returns valid=11
    logic        stub_ovr_en = 1'b0;
    logic [15:0] stub_ovr = 16'h0;
    logic [49:0] stub_last;
    int          stub_issues = 0;
    int          op_cycles = 0;

    function automatic logic [15:0] core_f(input logic [1:0] op, input logic [15:0] d,
                                           input logic [31:0] k);
        return d ^ k[15:0] ^ k[31:16] ^ ((op == 2'b10) ? 16'hC3C3 : 16'h0000);
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            cu_valid    <= 2'b00;
            cu_out_data <= 16'h0;
            stub_last   <= '0;
        end else if (cu_opcode != 2'b00 && {cu_opcode, cu_in_data, cu_key} != stub_last) begin
            stub_last   <= {cu_opcode, cu_in_data, cu_key};
            stub_issues <= stub_issues + 1;
            cu_valid    <= (stub_mode == 1) ? 2'b00 : (stub_mode == 2) ? 2'b11 : cu_opcode;
            cu_out_data <= stub_ovr_en ? stub_ovr : core_f(cu_opcode, cu_in_data, cu_key);
        end else begin
            cu_valid <= 2'b00;
        end
    end

    always @(negedge clk) if (cu_opcode != 2'b00) op_cycles++;

    // Reference model: request-level rules, assuming the core answers every issued request.
    logic [49:0] m_last;
    logic [15:0] m_cache;
    logic        m_ok;
    int          m_req, m_hit, m_err;
    logic [18:0] exp_q[$];

    function automatic void model_reset();
        m_last = '0; m_cache = '0; m_ok = 1'b0;
        m_req = 0; m_hit = 0; m_err = 0;
        exp_q.delete();
    endfunction

    function automatic void model_step(input logic [1:0] op, input logic [15:0] d,
                                       input logic [31:0] k);
        logic [18:0] e;
        m_req++;
        if (op != 2'b01 && op != 2'b10) begin
            e = {op, 1'b1, 16'h0}; m_err++;
        end else if ({op, d, k} == m_last) begin
            if (m_ok) begin e = {op, 1'b0, m_cache}; m_hit++; end
            else      begin e = {op, 1'b1, 16'h0};   m_err++; end
        end else begin
            m_last = {op, d, k}; m_cache = core_f(op, d, k); m_ok = 1'b1;
            e = {op, 1'b0, m_cache};
        end
        exp_q.push_back(e);
    endfunction

    task automatic apply_reset();
        reset = 1'b1; req_valid = 1'b0; rsp_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        model_reset();
    endtask

    task automatic push(input logic [1:0] op, input logic [15:0] d, input logic [31:0] k);
        logic acc;
        int   i;
        req_valid = 1'b1; req_op = op; req_data = d; req_key = k;
        acc = 1'b0;
        for (i = 0; i < 200 && !acc; i++) begin
            acc = req_ready;
            @(posedge clk); #1;
        end
        req_valid = 1'b0;
        if (!acc) begin
            n_checks++; n_fail++;
            $display("FAIL push_timeout: req_ready stayed 0 for %0d cycles, required 1", i);
        end
    endtask

    task automatic wait_rsp(output int cyc);
        cyc = 0;
        while (!rsp_valid && cyc < 100) begin @(posedge clk); #1; cyc++; end
        if (!rsp_valid) begin
            n_checks++; n_fail++;
            $display("FAIL wait_rsp: rsp_valid=0 after %0d cycles, required 1", cyc);
        end
    endtask

    task automatic accept();
        rsp_ready = 1'b1; @(posedge clk); #1; rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        n_checks++;
        if ({req_ready, rsp_valid} !== 2'b10) begin
            n_fail++; $display("FAIL reset_handshake: ready/valid=%b required 10", {req_ready, rsp_valid});
        end
        n_checks++;
        if ({rsp_data, rsp_op, rsp_err} !== 19'h0) begin
            n_fail++; $display("FAIL reset_rsp: got %h required 0", {rsp_data, rsp_op, rsp_err});
        end
        n_checks++;
        if ({cu_opcode, cu_in_data, cu_key} !== 50'h0) begin
            n_fail++; $display("FAIL reset_cu: got %h required 0", {cu_opcode, cu_in_data, cu_key});
        end
    endtask

    task automatic test_miss();
        int cyc, iss0, oc0;
        stub_mode = 0; stub_ovr_en = 1'b1; stub_ovr = 16'hBEEF;
        iss0 = stub_issues; oc0 = op_cycles;
        push(2'b01, 16'h1234, 32'hA5A50F0F);
        wait_rsp(cyc);
        n_checks++;
        if (cyc !== 3) begin n_fail++; $display("FAIL miss_latency: got %0d required 3", cyc); end
        n_checks++;
        if ({rsp_op, rsp_err, rsp_data} !== {2'b01, 1'b0, 16'hBEEF}) begin
            n_fail++; $display("FAIL miss_rsp: got %h required %h", {rsp_op, rsp_err, rsp_data},
                               {2'b01, 1'b0, 16'hBEEF});
        end
        accept();
        n_checks++;
        if ((op_cycles - oc0) !== 2 || (stub_issues - iss0) !== 1) begin
            n_fail++; $display("FAIL miss_issue: opcode cycles %0d issues %0d required 2 and 1",
                               op_cycles - oc0, stub_issues - iss0);
        end
        n_checks++;
        if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL miss_accept: rsp_valid=%b required 0", rsp_valid); end
        stub_ovr_en = 1'b0;
    endtask

    task automatic test_repeat();
        int cyc, oc0;
        oc0 = op_cycles;
        push(2'b01, 16'h1234, 32'hA5A50F0F);
        wait_rsp(cyc);
        n_checks++;
        if (cyc !== 1) begin n_fail++; $display("FAIL hit_latency: got %0d required 1", cyc); end
        n_checks++;
        if ({rsp_op, rsp_err, rsp_data} !== {2'b01, 1'b0, 16'hBEEF} || op_cycles != oc0) begin
            n_fail++; $display("FAIL hit_rsp: got %h opcycles %0d required %h opcycles 0",
                               {rsp_op, rsp_err, rsp_data}, op_cycles - oc0, {2'b01, 1'b0, 16'hBEEF});
        end
`ifdef SPN_SCHED_STATS_EN
        n_checks++;
        if ({stat_req, stat_hit} !== {16'd2, 16'd1}) begin
            n_fail++; $display("FAIL hit_stats: req %0d hit %0d required 2 and 1", stat_req, stat_hit);
        end
`endif
        accept();
    endtask

    task automatic test_illegal();
        int cyc, oc0;
        oc0 = op_cycles;
        push(2'b11, 16'h0001, 32'h0);
        wait_rsp(cyc);
        n_checks++;
        if (cyc !== 1 || {rsp_op, rsp_err, rsp_data} !== {2'b11, 1'b1, 16'h0}) begin
            n_fail++; $display("FAIL illegal_rsp: lat %0d got %h required lat 1 %h", cyc,
                               {rsp_op, rsp_err, rsp_data}, {2'b11, 1'b1, 16'h0});
        end
        accept();
        n_checks++;
        if (op_cycles != oc0) begin n_fail++; $display("FAIL illegal_issue: opcode busy %0d cycles required 0", op_cycles - oc0); end
    endtask

    task automatic test_timeout();
        int cyc, iss0;
        stub_mode = 1;
        push(2'b10, 16'h4321, 32'h11112222);
        wait_rsp(cyc);
        n_checks++;
        if (cyc !== TIMEOUT + 1 || {rsp_op, rsp_err, rsp_data} !== {2'b10, 1'b1, 16'h0}) begin
            n_fail++; $display("FAIL timeout_rsp: lat %0d got %h required lat %0d %h", cyc,
                               {rsp_op, rsp_err, rsp_data}, TIMEOUT + 1, {2'b10, 1'b1, 16'h0});
        end
        accept();
        iss0 = stub_issues;
        stub_mode = 0;
        push(2'b10, 16'h4321, 32'h11112222);
        wait_rsp(cyc);
        n_checks++;
        if (cyc !== 1 || rsp_err !== 1'b1 || stub_issues != iss0) begin
            n_fail++; $display("FAIL timeout_repeat: lat %0d err %b reissues %0d required 1 1 0",
                               cyc, rsp_err, stub_issues - iss0);
        end
        accept();
        stub_mode = 2;
        push(2'b01, 16'h7777, 32'h12345678);
        wait_rsp(cyc);
        n_checks++;
        if (cyc !== 3 || {rsp_op, rsp_err, rsp_data} !== {2'b01, 1'b1, 16'h0}) begin
            n_fail++; $display("FAIL badvalid_rsp: lat %0d got %h required lat 3 %h", cyc,
                               {rsp_op, rsp_err, rsp_data}, {2'b01, 1'b1, 16'h0});
        end
        accept();
        stub_mode = 0;
    endtask

    task automatic test_reset_wait();
        int cyc, iss0;
        stub_mode = 1;
        push(2'b01, 16'h0005, 32'h6);
        push(2'b10, 16'h0007, 32'h8);
        push(2'b01, 16'h0009, 32'hA);
        n_checks++;
        if (cu_opcode !== 2'b01) begin n_fail++; $display("FAIL rstwait_pre: cu_opcode=%b required 01", cu_opcode); end
        reset = 1'b1; @(posedge clk); #1 reset = 1'b0;
        model_reset();
        n_checks++;
        if ({req_ready, rsp_valid, rsp_data, rsp_op, rsp_err, cu_opcode, cu_in_data, cu_key} !==
            {1'b1, 70'h0}) begin
            n_fail++; $display("FAIL rstwait_outputs: got %h required %h",
                {req_ready, rsp_valid, rsp_data, rsp_op, rsp_err, cu_opcode, cu_in_data, cu_key}, {1'b1, 70'h0});
        end
        stub_mode = 0;
        iss0 = stub_issues; cyc = 0;
        repeat (10) begin @(posedge clk); #1; if (rsp_valid || cu_opcode != 2'b00) cyc++; end
        n_checks++;
        if (cyc != 0 || stub_issues != iss0) begin
            n_fail++; $display("FAIL rstwait_fifo_empty: activity %0d cycles required 0", cyc);
        end
        push(2'b01, 16'h0, 32'h0);
        wait_rsp(cyc);
        n_checks++;
        if (cyc !== 3 || {rsp_op, rsp_err} !== 3'b010 || stub_issues != iss0 + 1) begin
            n_fail++; $display("FAIL rstwait_miss: lat %0d op/err %b issues %0d required 3 010 1",
                               cyc, {rsp_op, rsp_err}, stub_issues - iss0);
        end
        accept();
    endtask

    task automatic test_backpressure();
        int cyc, got, last_t;
        logic [18:0] e;
        apply_reset();
        stub_mode = 0;
        for (int i = 0; i < 5; i++) begin
            model_step(i[0] ? 2'b10 : 2'b01, 16'h1000 + 16'(i), 32'hCAFE0000 + 32'(i));
            push(i[0] ? 2'b10 : 2'b01, 16'h1000 + 16'(i), 32'hCAFE0000 + 32'(i));
        end
        n_checks++;
        if (req_ready !== 1'b0) begin n_fail++; $display("FAIL bp_full: req_ready=%b required 0", req_ready); end
        req_valid = 1'b1; req_op = 2'b01; req_data = 16'hDEAD; req_key = 32'h0;
        repeat (3) begin @(posedge clk); #1; end
        req_valid = 1'b0;
        n_checks++;
        if (req_ready !== 1'b0) begin n_fail++; $display("FAIL bp_hold: req_ready=%b required 0", req_ready); end
        rsp_ready = 1'b1;
        got = 0; cyc = 0; last_t = 0;
        while (got < 5 && cyc < 200) begin
            if (rsp_valid) begin
                e = exp_q.pop_front();
                n_checks++;
                if ({rsp_op, rsp_err, rsp_data} !== e) begin
                    n_fail++; $display("FAIL bp_order[%0d]: got %h required %h", got, {rsp_op, rsp_err, rsp_data}, e);
                end
                if (got > 0) begin
                    n_checks++;
                    if (cyc - last_t != 4) begin n_fail++; $display("FAIL bp_throughput[%0d]: gap %0d required 4", got, cyc - last_t); end
                end
                last_t = cyc; got++;
            end
            @(posedge clk); #1; cyc++;
        end
        cyc = 0;
        repeat (12) begin @(posedge clk); #1; if (rsp_valid) cyc++; end
        rsp_ready = 1'b0;
        n_checks++;
        if (got != 5 || cyc != 0) begin
            n_fail++; $display("FAIL bp_count: got %0d extra %0d required 5 and 0", got, cyc);
        end
    endtask

    task automatic test_random();
        localparam int N = 60;
        int got, cyc;
        logic [18:0] e;
        logic [1:0]  op;
        logic [15:0] d;
        logic [31:0] k;
        apply_reset();
        stub_mode = 0;
        got = 0;
        fork
            begin
                op = 2'b01; d = 0; k = 0;
                for (int i = 0; i < N; i++) begin
                    if ($urandom_range(0, 2) != 0 || i == 0) begin
                        op = ($urandom_range(0, 7) == 0) ? 2'(($urandom_range(0, 1)) * 3) :
                             ($urandom_range(0, 1) ? 2'b01 : 2'b10);
                        d = 16'($urandom_range(0, 3));
                        k = 32'($urandom_range(0, 1)) << 20;
                    end
                    model_step(op, d, k);
                    push(op, d, k);
                    repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
                end
            end
            begin
                cyc = 0;
                while (got < N && cyc < 5000) begin
                    rsp_ready = $urandom_range(0, 1) ? 1'b1 : 1'b0;
                    if (rsp_valid && rsp_ready) begin
                        n_checks++;
                        if (exp_q.size() == 0) begin
                            n_fail++; $display("FAIL rand_extra[%0d]: unexpected response %h", got, {rsp_op, rsp_err, rsp_data});
                        end else begin
                            e = exp_q.pop_front();
                            if ({rsp_op, rsp_err, rsp_data} !== e) begin
                                n_fail++; $display("FAIL rand_rsp[%0d]: got %h required %h", got, {rsp_op, rsp_err, rsp_data}, e);
                            end
                        end
                        got++;
                    end
                    @(posedge clk); #1; cyc++;
                end
                rsp_ready = 1'b0;
            end
        join
        n_checks++;
        if (got != N) begin n_fail++; $display("FAIL rand_count: got %0d required %0d", got, N); end
`ifdef SPN_SCHED_STATS_EN
        n_checks++;
        if ({stat_req, stat_hit, stat_err} !== {16'(m_req), 16'(m_hit), 16'(m_err)}) begin
            n_fail++; $display("FAIL rand_stats: got %0d/%0d/%0d required %0d/%0d/%0d",
                               stat_req, stat_hit, stat_err, m_req, m_hit, m_err);
        end
`endif
    endtask

    initial begin
        reset = 1'b1; req_valid = 1'b0; rsp_ready = 1'b0;
        req_op = 2'b00; req_data = 16'h0; req_key = 32'h0;
        test_reset();
        test_miss();
        test_repeat();
        test_illegal();
        test_timeout();
        test_reset_wait();
        test_backpressure();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
